i2s_tx: RTL
===========

# i2s_tx

I2S audio transmitter for the codec DAC path. The block runs directly on the divided bit clock from `clk_div_master` (50 MHz / 8 = 6.25 MHz), which is also the codec BCLK pin. It accepts stereo sample pairs over a valid/ready handshake and serialises them as standard I2S frames of 64 bit clocks, generating LRCK alongside the data. The frame rate is 97.656 kHz.

## Interface
- `DATA_WIDTH`, default 16: bits per channel sample; legal range 1..31.
- `clk_in`  input  1: bit clock (`clk_div_master.clk_out`); all logic on its rising edge.
- `ar`  input  1: asynchronous, active-low reset.
- `left_in`  input  DATA_WIDTH: left sample, two's complement, MSB first on the wire.
- `right_in`  input  DATA_WIDTH: right sample.
- `in_valid`  input  1: sample pair on `left_in`/`right_in` is valid.
- `in_ready`  output  1: holding register empty; pair accepted on an edge where `in_valid & in_ready`.
- `lrck_out`  output  1: codec LRCK; 0 = left slot, 1 = right slot.
- `sdata_out`  output  1: codec DACDAT.
- `underrun`  output  1: one-cycle pulse when a frame starts with no sample pending.

## Operation
- 6-bit slot counter `cnt`, 0..63.
  - Increments every edge; wraps 63→0.
  - Each wrap to 0 is the frame boundary.
- Single-entry holding register plus `full` flag.
  - Accept on `in_valid & in_ready`: capture `left_in`/`right_in`, set `full`.
  - `in_ready` = ~`full`, driven from a register; it is not combinational from `in_valid`.
- Frame latch, on the edge where `cnt` goes 63→0:
  - If `full`: copy the holding pair into the transmit registers and clear `full`. `in_ready` rises in the `cnt`=0 cycle.
  - If not `full`: load zeros into the transmit registers and pulse `underrun` for the `cnt`=0 cycle only.
  - An accept on the same edge as a latch with `full`=0 goes into the holding register. It is not bypassed into the current frame; it is sent in the next frame.
- Slot content for the cycle where `cnt` = k. `lrck_out` and `sdata_out` are both registered on the edge into k.
  - `lrck_out` = 1 iff k ≥ 32.
  - k = 1..DATA_WIDTH: `sdata_out` = left[DATA_WIDTH−k], so the MSB is at k = 1.
  - k = 33..32+DATA_WIDTH: `sdata_out` = right[DATA_WIDTH−(k−32)].
  - All other k, including 0 and 32: `sdata_out` = 0.
  - This gives the I2S one-bit delay after each LRCK transition. Unused LSB slots are zero-padded.
- Reset (`ar` = 0) forces, immediately and regardless of clock:
  - `cnt` = 0, `full` = 0, transmit registers = 0.
  - `lrck_out` = 0, `sdata_out` = 0, `underrun` = 0, `in_ready` = 1.
  - Reset mid-frame discards the in-flight frame and any pending sample.
- The first frame after reset is all zeros by construction. `underrun` is not asserted for it because no latch edge has occurred yet.

## Timing
- Outputs change only on the `clk_in` rising edge (plus async reset). The codec samples DACDAT/LRCK on the following rising BCLK edge; one full 160 ns period gives setup margin.
- Accept-to-wire latency: the pair goes out in the frame beginning at the first 63→0 edge after acceptance. The left MSB appears one cycle after that edge.
- Throughput: one pair per 64 cycles. `in_ready` deasserts for the rest of the frame after an accept.
- Reset release: the first edge with `ar` = 1 moves `cnt` 0→1. Reset must be deasserted synchronously to `clk_in` by the existing reset synchroniser.

## Test plan
- Reset: hold `ar` = 0 with clock running → `lrck_out` = 0, `sdata_out` = 0, `underrun` = 0, `in_ready` = 1 throughout.
- Single pair, DATA_WIDTH = 16: accept left = 16'hA5C3, right = 16'h8001 during frame 0.
  - Frame 1, `cnt` 1..16, reads A5C3 MSB first.
  - `cnt` 17..32 reads zeros.
  - Right slot (`cnt` 33..48) reads 8001; `cnt` 49..63 reads zeros.
  - LRCK is low for `cnt` 0..31 and high for 32..63.
- Back-pressure: hold `in_valid` = 1 with incrementing pairs → exactly one accept per 64 cycles. The accept lands in the `cnt`=0 cycle after each latch. No `underrun` after the first latch.
- Underrun: supply no data → `underrun` pulses for one cycle at every `cnt`=0 after the first wrap, and `sdata_out` stays 0.
- Simultaneous accept at a latch with `full` = 0 → `underrun` pulses, the current frame is zeros, and the pair is transmitted in the next frame.
- Mid-frame reset: assert `ar` at `cnt` = 40 while the right slot is shifting → outputs go to reset values asynchronously. After release, the frame restarts at `cnt` = 0 and the pending sample is gone (zeros plus `underrun` at the first latch).

Source files
------------

// File: rtl/i2s_tx.sv
// i2s_tx -- I2S audio transmitter for the codec DAC path.
//
// Runs on the codec bit clock. Each frame is 64 bit clocks long.
// One stereo pair is taken in through a valid/ready handshake and sent as a
// standard I2S frame:
//   - LRCK is low for the left slot and high for the right slot.
//   - Data is sent MSB first, with a one-bit delay after each LRCK edge.
//
// Ports:
//   clk_in    : bit clock; all logic runs on its rising edge
//   ar        : asynchronous reset, active low
//   left_in   : left sample, two's complement (DATA_WIDTH bits)
//   right_in  : right sample, two's complement (DATA_WIDTH bits)
//   in_valid  : the pair on left_in/right_in is valid
//   in_ready  : the holding register is empty (registered output)
//   lrck_out  : codec LRCK; 0 = left slot, 1 = right slot
//   sdata_out : codec DACDAT
//   underrun  : one-cycle pulse when a frame starts with no sample pending
module i2s_tx #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk_in,
  input  logic                  ar,
  input  logic [DATA_WIDTH-1:0] left_in,
  input  logic [DATA_WIDTH-1:0] right_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  lrck_out,
  output logic                  sdata_out,
  output logic                  underrun
);

  logic [5:0]            cnt;
  logic [5:0]            cnt_next;
  logic                  full;
  logic                  full_next;
  logic [DATA_WIDTH-1:0] hold_left;
  logic [DATA_WIDTH-1:0] hold_right;
  logic [63:0]           tx_frame;
  logic [63:0]           frame_next;
  logic                  accept;
  logic                  latch;

  assign accept   = in_valid & in_ready;
  assign latch    = (cnt == 6'd63);
  assign cnt_next = cnt + 6'd1;

  // The transmit register holds the whole frame as it appears on the wire.
  // Bit (63 - k) is the data bit for slot k.
  // Slots 0 and 32 are always 0 (the I2S delay bit).
  // Unused LSB slots stay 0.
  // A frame latched with nothing pending is all zeros.
  always_comb begin
    frame_next = '0;
    if (full) begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        frame_next[62-i] = hold_left[DATA_WIDTH-1-i];
        frame_next[30-i] = hold_right[DATA_WIDTH-1-i];
      end
    end
  end

  // An accept can never coincide with a latch that has full set, because
  // in_ready is low then. So "accept wins" also covers a fresh pair arriving
  // on an underrun latch: that pair waits for the next frame.
  always_comb begin
    full_next = full;
    if (accept) begin
      full_next = 1'b1;
    end else if (latch) begin
      full_next = 1'b0;
    end
  end

  // Every output is registered from next-cycle values, so that it changes
  // only on the clk_in rising edge.
  // ~cnt_next is the same as 63 - cnt_next, which is the frame bit for the
  // slot being entered.
  always_ff @(posedge clk_in or negedge ar) begin
    if (!ar) begin
      cnt        <= 6'd0;
      full       <= 1'b0;
      in_ready   <= 1'b1;
      hold_left  <= '0;
      hold_right <= '0;
      tx_frame   <= '0;
      underrun   <= 1'b0;
      lrck_out   <= 1'b0;
      sdata_out  <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      full     <= full_next;
      in_ready <= ~full_next;
      if (accept) begin
        hold_left  <= left_in;
        hold_right <= right_in;
      end
      if (latch) begin
        tx_frame <= frame_next;
      end
      underrun  <= latch & ~full;
      lrck_out  <= cnt_next[5];
      sdata_out <= tx_frame[~cnt_next];
    end
  end

endmodule
